// File: rtl/alu_pipe.sv
// Handshaked two-word ALU: lane-wise ADD/SUB, logic ops, iterative unsigned MULT/DIV.
// Define ALU_PIPE_DIV_EN to build the restoring divider; otherwise DIV is a 1-cycle stub.
module alu_pipe #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             form,
  input  logic [1:0]       vec,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic             div0,
  output logic             busy
);
  localparam int N  = WIDTH / STEP_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int NB = 2 * WIDTH / 8;

  typedef enum logic {IDLE, ITER} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi, lo, c_q;
`ifdef ALU_PIPE_DIV_EN
  logic               is_div_q, div0_q;
`endif
  logic               accept, start_iter, last;
  logic [2*WIDTH-1:0] as_x, as_y, as_sum;
  logic               as_sub, carry, lane_start;
  logic [8:0]         byte_sum;
  logic [WIDTH-1:0]   r1, r2;
  logic               r_div0;
  logic [WIDTH:0]     hi_t;
  logic [WIDTH-1:0]   lo_t;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ITER);
  assign last     = (state == ITER) && (count == CW'(N - 1));
`ifdef ALU_PIPE_DIV_EN
  assign start_iter = (op == 3'b001) || (op == 3'b101);
`else
  assign start_iter = (op == 3'b001);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && start_iter) state_nxt = ITER;
      ITER:    if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte-wise carry chain over {A,B}+{C,D}; the chain restarts at each lane boundary.
  always_comb begin
    as_sub     = op[2];
    as_x       = {A, B};
    as_y       = as_sub ? ~{C, D} : {C, D};
    as_sum     = '0;
    carry      = as_sub;
    lane_start = 1'b0;
    byte_sum   = '0;
    for (int i = 0; i < NB; i++) begin
      case (vec)
        2'b00:   lane_start = 1'b1;
        2'b01:   lane_start = (i % 2) == 0;
        2'b10:   lane_start = (i % (WIDTH / 8)) == 0;
        default: lane_start = (i == 0);
      endcase
      if (lane_start) carry = as_sub;
      byte_sum = {1'b0, as_x[8*i +: 8]} + {1'b0, as_y[8*i +: 8]} + {8'b0, carry};
      as_sum[8*i +: 8] = byte_sum[7:0];
      carry = byte_sum[8];
    end
  end

  always_comb begin
    r1     = '0;
    r2     = '0;
    r_div0 = 1'b0;
    case (op)
      3'b000, 3'b100: {r1, r2} = as_sum;
      3'b010: begin r1 = A & C; r2 = B & D; end
      3'b011: begin r1 = A | C; r2 = B | D; end
      3'b110: begin r1 = A ^ C; r2 = B ^ D; end
      3'b111: begin r1 = A;     r2 = B;     end
      3'b101: begin r1 = '1;    r2 = A;     r_div0 = 1'b1; end
      default: ;
    endcase
    if (op[1] && form) begin
      r1 = ~r1;
      r2 = ~r2;
    end
  end

  // hi/lo hold {product high, multiplier/low} for MULT and {remainder, quotient} for DIV.
  always_comb begin
    hi_t = {1'b0, hi};
    lo_t = lo;
    for (int s = 0; s < STEP_BITS; s++) begin
`ifdef ALU_PIPE_DIV_EN
      if (is_div_q) begin
        hi_t = {hi_t[WIDTH-1:0], lo_t[WIDTH-1]};
        lo_t = {lo_t[WIDTH-2:0], 1'b0};
        if (hi_t >= {1'b0, c_q}) begin
          hi_t    = hi_t - {1'b0, c_q};
          lo_t[0] = 1'b1;
        end
      end else
`endif
      begin
        if (lo_t[0]) hi_t = {1'b0, hi_t[WIDTH-1:0]} + {1'b0, c_q};
        lo_t = {hi_t[0], lo_t[WIDTH-1:1]};
        hi_t = {1'b0, hi_t[WIDTH:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y1        <= '0;
      Y2        <= '0;
      div0      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      c_q       <= '0;
      count     <= '0;
`ifdef ALU_PIPE_DIV_EN
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
`endif
    end else if (accept && start_iter) begin
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= A;
      c_q       <= C;
      count     <= '0;
`ifdef ALU_PIPE_DIV_EN
      is_div_q  <= op[2];
      div0_q    <= (C == '0);
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      Y1        <= r1;
      Y2        <= r2;
      div0      <= r_div0;
    end else if (state == ITER) begin
      hi    <= hi_t[WIDTH-1:0];
      lo    <= lo_t;
      count <= count + CW'(1);
      if (last) begin
        out_valid <= 1'b1;
`ifdef ALU_PIPE_DIV_EN
        if (is_div_q) begin
          Y1   <= lo_t;
          Y2   <= hi_t[WIDTH-1:0];
          div0 <= div0_q;
        end else begin
          Y1   <= hi_t[WIDTH-1:0];
          Y2   <= lo_t;
          div0 <= 1'b0;
        end
`else
        Y1   <= hi_t[WIDTH-1:0];
        Y2   <= lo_t;
        div0 <= 1'b0;
`endif
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
